// File: rtl/led_cmd_parser.sv
// led_cmd_parser: parses opcode frames from the SPI byte stream into a
// per-LED enable mask and PWM duty registers, and drives the LEDs with PWM.
// Optional: define LEDCMD_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES idle clocks between argument bytes.
module led_cmd_parser #(
    parameter int NUM_LEDS       = 4,
    parameter int PWM_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          cmd,
    input  logic                cmd_valid,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                err,
    output logic [7:0]          last_op
);

    localparam logic [7:0] OP_SET_MASK = 8'h10;
    localparam logic [7:0] OP_SET_DUTY = 8'h20;
    localparam logic [7:0] OP_ALL_OFF  = 8'h30;
    localparam logic [7:0] OP_CLR_ERR  = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2
    } state_t;

    // Elaboration-time guard against unsupported configurations.
    if (NUM_LEDS < 1 || NUM_LEDS > 8 || PWM_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("led_cmd_parser: unsupported parameter values");
    end

    state_t                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [7:0]            idx_q, idx_d;
    logic [NUM_LEDS-1:0]   mask_q, mask_d;
    logic [PWM_WIDTH-1:0]  duty_q [NUM_LEDS];
    logic [PWM_WIDTH-1:0]  duty_d [NUM_LEDS];
    logic [PWM_WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic                  err_q, err_d;
    logic [7:0]            last_op_q, last_op_d;

`ifdef LEDCMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

    // Next-state decode: frame parsing, register writes, PWM compare.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        duty_d    = duty_q;
        err_d     = err_q;
        last_op_d = last_op_q;
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);

        // Compare uses the current mask/duty so changes apply mid-period.
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = mask_q[i] & (pwm_cnt_q < duty_q[i]);
        end

        if (cmd_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    case (cmd)
                        OP_SET_MASK, OP_SET_DUTY: begin
                            op_d    = cmd;
                            state_d = ST_ARG1;
                        end
                        OP_ALL_OFF: begin
                            mask_d    = '0;
                            last_op_d = cmd;
                        end
                        OP_CLR_ERR: begin
                            err_d     = 1'b0;
                            last_op_d = cmd;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                ST_ARG1: begin
                    if (op_q == OP_SET_MASK) begin
                        mask_d    = cmd[NUM_LEDS-1:0];
                        last_op_d = OP_SET_MASK;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d   = cmd;
                        state_d = ST_ARG2;
                    end
                end
                ST_ARG2: begin
                    if (idx_q < 8'(NUM_LEDS)) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (idx_q == 8'(i)) duty_d[i] = PWM_WIDTH'(cmd);
                        end
                        last_op_d = OP_SET_DUTY;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef LEDCMD_TIMEOUT_EN
        // A strobe always restarts the idle count and wins over expiry.
        to_cnt_d = '0;
        if (!cmd_valid && state_q != ST_IDLE) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            idx_q     <= '0;
            mask_q    <= '0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
            err_q     <= 1'b0;
            last_op_q <= '0;
            // NOTE: the duty array is a handful of flops that must read zero
            // after reset, so it is reset like any other register rather than
            // being left uninitialised as a RAM would be.
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
`ifdef LEDCMD_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            err_q     <= err_d;
            last_op_q <= last_op_d;
            duty_q    <= duty_d;
`ifdef LEDCMD_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign led     = led_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;
    assign last_op = last_op_q;

endmodule

// File: tb/tb_led_cmd_parser.sv
// Self-checking bench for led_cmd_parser: directed frames from the test plan
// followed by random byte traffic, compared cycle by cycle with a frame-level
// reference model (bytes collected into a queue, executed when complete).
module tb_led_cmd_parser;

    localparam int NL  = 4;
    localparam int PW  = 8;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cmd;
    logic          cmd_valid;
    logic [NL-1:0] led;
    logic          busy;
    logic          err;
    logic [7:0]    last_op;

    always #5 clk = ~clk;

    led_cmd_parser #(
        .NUM_LEDS      (NL),
        .PWM_WIDTH     (PW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .led      (led),
        .busy     (busy),
        .err      (err),
        .last_op  (last_op)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_mask;
    int m_duty [NL];
    bit m_err;
    int m_last_op;
    int m_frame [$];
    int m_cnt;
    int m_led;
    int m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int op);
        if (op == 'h10) return 2;
        if (op == 'h20) return 3;
        return 1;
    endfunction

    task automatic model_reset();
        m_mask = 0;
        for (int i = 0; i < NL; i++) m_duty[i] = 0;
        m_err = 0;
        m_last_op = 0;
        m_frame.delete();
        m_cnt = 0;
        m_led = 0;
        m_idle = 0;
    endtask

    // One clock edge of the model: LEDs follow the pre-edge mask/duty/counter.
    task automatic model_edge(input bit v, input int b);
        int nxt_led;
        nxt_led = 0;
        for (int i = 0; i < NL; i++)
            if (m_mask[i] && m_cnt < m_duty[i]) nxt_led |= (1 << i);
        if (v) begin
            m_idle = 0;
            if (m_frame.size() == 0) begin
                case (b)
                    'h10, 'h20: m_frame.push_back(b);
                    'h30: begin m_mask = 0; m_last_op = b; end
                    'h40: begin m_err = 0; m_last_op = b; end
                    default: m_err = 1;
                endcase
            end else begin
                m_frame.push_back(b);
                if (m_frame.size() == frame_len(m_frame[0])) begin
                    if (m_frame[0] == 'h10) begin
                        m_mask = m_frame[1] % (1 << NL);
                        m_last_op = 'h10;
                    end else if (m_frame[1] < NL) begin
                        m_duty[m_frame[1]] = m_frame[2] % (1 << PW);
                        m_last_op = 'h20;
                    end else begin
                        m_err = 1;
                    end
                    m_frame.delete();
                end
            end
        end
`ifdef LEDCMD_TIMEOUT_EN
        else if (m_frame.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_frame.delete();
                m_err = 1;
                m_idle = 0;
            end
        end
`endif
        m_led = nxt_led;
        m_cnt = (m_cnt + 1) % (1 << PW);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".led"},     32'(led),     32'(m_led));
        check({tag, ".busy"},    32'(busy),    32'(m_frame.size() != 0));
        check({tag, ".err"},     32'(err),     32'(m_err));
        check({tag, ".last_op"}, 32'(last_op), 32'(m_last_op));
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input bit v, input logic [7:0] b, input string tag);
        cmd       = b;
        cmd_valid = v;
        @(posedge clk);
        model_edge(v, int'(b));
        @(negedge clk);
        cmd_valid = 1'b0;
        compare_all(tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        cyc(1'b1, b, tag);
    endtask

    // Idle for n cycles, counting cycles where led[bit_i] (or any led if
    // bit_i < 0) is high.
    task automatic run_count(input int n, input int bit_i, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 8'h00, "idle");
            if (bit_i < 0) begin
                if (led != '0) hi++;
            end else if (led[bit_i]) begin
                hi++;
            end
        end
    endtask

    initial begin
        int hi;
        int v;
        logic [7:0] b;
        logic [7:0] ops [4];

        rst = 1'b1;
        cmd = 8'h00;
        cmd_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // Mask 0x0F, duty[2]=0x80 -> 50% on led[2], others dark.
        send(8'h10, "mask"); send(8'h0F, "mask");
        send(8'h20, "duty2"); send(8'h02, "duty2"); send(8'h80, "duty2");
        check("last_op_set_duty", 32'(last_op), 32'h20);
        run_count(256, 2, hi);
        check("led2_high_128", 32'(hi), 32'd128);
        run_count(256, 0, hi);
        check("led0_dark", 32'(hi), 32'd0);

        // Back-to-back frames: duty[1]=0xFF then mask=0x02.
        send(8'h20, "b2b"); send(8'h01, "b2b"); send(8'hFF, "b2b");
        send(8'h10, "b2b"); send(8'h02, "b2b");
        run_count(256, 1, hi);
        check("led1_high_255", 32'(hi), 32'd255);

        // Bad opcode sets err, parsing continues, CLR_ERR clears it.
        send(8'h55, "badop");
        check("err_after_badop", 32'(err), 32'd1);
        check("idle_after_badop", 32'(busy), 32'd0);
        send(8'h10, "mask1"); send(8'h01, "mask1");
        send(8'h40, "clr");
        check("err_cleared", 32'(err), 32'd0);

        // Out-of-range index: error, no write, trailing 0x10 was an argument.
        send(8'h20, "badidx"); send(8'h07, "badidx"); send(8'h10, "badidx");
        check("err_badidx", 32'(err), 32'd1);
        check("last_op_badidx", 32'(last_op), 32'h40);
        send(8'h10, "after_badidx"); send(8'h0F, "after_badidx");
        run_count(256, -1, hi);
        send(8'h40, "clr2");

        // All duties 0x40 under full mask, then ALL_OFF.
        for (int i = 0; i < NL; i++) begin
            send(8'h20, "dall"); send(8'(i), "dall"); send(8'h40, "dall");
        end
        run_count(256, 3, hi);
        check("led3_high_64", 32'(hi), 32'd64);
        send(8'h30, "alloff");
        run_count(300, -1, hi);
        check("alloff_dark", 32'(hi), 32'd0);

        // Reset in the middle of a frame.
        send(8'h10, "mask_pre"); send(8'h0F, "mask_pre");
        send(8'h20, "midframe");
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all("rst_mid");
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h10, "mask_post"); send(8'h0F, "mask_post");
        run_count(256, -1, hi);
        check("duties_zero_after_rst", 32'(hi), 32'd0);

`ifdef LEDCMD_TIMEOUT_EN
        // Partial frame abandoned after TMO idle cycles.
        send(8'h20, "tmo"); send(8'h01, "tmo");
        run_count(TMO, -1, hi);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        send(8'h40, "tmo_clr");
        // Third byte on cycle TMO-1 still completes the frame.
        send(8'h20, "tmo_ok"); send(8'h01, "tmo_ok");
        run_count(TMO - 2, -1, hi);
        send(8'hA0, "tmo_ok");
        check("tmo_ok_err", 32'(err), 32'd0);
        check("tmo_ok_last_op", 32'(last_op), 32'h20);
`else
        // Without the timeout a partial frame waits indefinitely.
        send(8'h20, "wait"); send(8'h01, "wait");
        run_count(300, -1, hi);
        check("wait_busy", 32'(busy), 32'd1);
        send(8'hA0, "wait");
        check("wait_last_op", 32'(last_op), 32'h20);
        check("wait_err", 32'(err), 32'd0);
`endif

        // Random traffic: opcodes, small indices and arbitrary bytes.
        ops[0] = 8'h10; ops[1] = 8'h20; ops[2] = 8'h30; ops[3] = 8'h40;
        for (int k = 0; k < 4000; k++) begin
            v = $urandom_range(0, 2);
            if (v == 0)      b = ops[$urandom_range(0, 3)];
            else if (v == 1) b = 8'($urandom_range(0, 7));
            else             b = 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) != 0, b, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
